fibgen_sweep_ctrl: RTL and testbench

//  Sequencer for one fibgen instance. Sweeps the 2-digit BCD generation amount from LO to HI.
//  For each amount it runs the start/ready/done handshake and reports each 4-digit BCD result.

---
 rtl/fibgen_pkg.sv | 19 +
 rtl/bcd2_inc.sv | 27 ++
 rtl/fibgen_sweep_ctrl.sv | 149 ++++++++++++++
 tb/tb_fibgen_sweep_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fibgen_pkg.sv
// Shared types for the fibgen sweep controller: BCD digit type and sequencer states.
package fibgen_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT_RDY,
    S_START,
    S_WAIT_DONE,
    S_REPORT,
    S_NEXT,
    S_FINISH
  } sweep_state_t;

endpackage

// File: rtl/bcd2_inc.sv
// Combinational 2-digit BCD incrementer; carry flags a wrap from 99 to 00.
module bcd2_inc
  import fibgen_pkg::*;
(
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [3:0] next_tens,
  output logic [3:0] next_ones,
  output logic       carry
);

  always_comb begin
    next_tens = tens;
    next_ones = ones + 4'd1;
    carry     = 1'b0;
    if (ones >= BCD_MAX) begin
      next_ones = '0;
      if (tens >= BCD_MAX) begin
        next_tens = '0;
        carry     = 1'b1;
      end else begin
        next_tens = tens + 4'd1;
      end
    end
  end

endmodule

// File: rtl/fibgen_sweep_ctrl.sv
// Sweeps the fibgen BCD amount from LO to HI, running one start/done handshake per
// amount, reporting each result and remembering the first overflowing amount.
module fibgen_sweep_ctrl
  import fibgen_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned STOP_ON_OVF    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sweep_start,
  input  logic       i_stop,
  input  logic [3:0] i_lo_bcd1,
  input  logic [3:0] i_lo_bcd0,
  input  logic [3:0] i_hi_bcd1,
  input  logic [3:0] i_hi_bcd0,
  output logic       o_fib_start,
  output logic [3:0] o_fib_amt_bcd1,
  output logic [3:0] o_fib_amt_bcd0,
  input  logic       i_fib_ready,
  input  logic       i_fib_done,
  input  logic       i_fib_overflow,
  input  logic [3:0] i_fib_bcd3,
  input  logic [3:0] i_fib_bcd2,
  input  logic [3:0] i_fib_bcd1,
  input  logic [3:0] i_fib_bcd0,
  output logic       o_busy,
  output logic       o_result_valid,
  output logic [3:0] o_result_amt_bcd1,
  output logic [3:0] o_result_amt_bcd0,
  output logic [3:0] o_result_bcd3,
  output logic [3:0] o_result_bcd2,
  output logic [3:0] o_result_bcd1,
  output logic [3:0] o_result_bcd0,
  output logic       o_result_ovf,
  output logic       o_first_ovf_valid,
  output logic [3:0] o_first_ovf_bcd1,
  output logic [3:0] o_first_ovf_bcd0,
  output logic       o_sweep_done,
  output logic       o_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  sweep_state_t     state, state_nxt;
  bcd_t             lo1, lo0, hi1, hi0;
  bcd_t             amt1, amt0, amt1_inc, amt0_inc;
  logic             amt_carry;
  logic [CNT_W-1:0] cnt;
  logic             cfg_bad, timeout, sweep_last;

  bcd2_inc u_inc (
    .tens      (amt1),
    .ones      (amt0),
    .next_tens (amt1_inc),
    .next_ones (amt0_inc),
    .carry     (amt_carry)
  );

  assign cfg_bad = (lo1 > BCD_MAX) || (lo0 > BCD_MAX) || (hi1 > BCD_MAX) || (hi0 > BCD_MAX)
                || ({hi1, hi0} < {lo1, lo0});
  assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // amt_carry only fires at 99, which always equals HI; it just guards against wrapping.
  assign sweep_last = ({amt1, amt0} == {hi1, hi0}) || i_stop || amt_carry
                   || ((STOP_ON_OVF != 0) && o_result_ovf);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (i_sweep_start) state_nxt = S_CHECK;
      S_CHECK:     state_nxt = cfg_bad ? S_FINISH : S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (i_stop)           state_nxt = S_FINISH;
        else if (i_fib_ready) state_nxt = S_START;
      end
      S_START:     state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (i_fib_done)   state_nxt = S_REPORT;
        else if (timeout) state_nxt = S_FINISH;
      end
      S_REPORT:    state_nxt = sweep_last ? S_FINISH : S_NEXT;
      S_NEXT:      state_nxt = S_WAIT_RDY;
      S_FINISH:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {lo1, lo0, hi1, hi0, amt1, amt0} <= '0;
      cnt               <= '0;
      o_result_amt_bcd1 <= '0;
      o_result_amt_bcd0 <= '0;
      {o_result_bcd3, o_result_bcd2, o_result_bcd1, o_result_bcd0} <= '0;
      o_result_ovf      <= 1'b0;
      o_first_ovf_valid <= 1'b0;
      o_first_ovf_bcd1  <= '0;
      o_first_ovf_bcd0  <= '0;
      o_err             <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (i_sweep_start) begin
          {lo1, lo0, hi1, hi0} <= {i_lo_bcd1, i_lo_bcd0, i_hi_bcd1, i_hi_bcd0};
          o_err             <= 1'b0;
          o_first_ovf_valid <= 1'b0;
          o_first_ovf_bcd1  <= '0;
          o_first_ovf_bcd0  <= '0;
        end
        S_CHECK: begin
          if (cfg_bad) o_err <= 1'b1;
          else         {amt1, amt0} <= {lo1, lo0};
        end
        S_START: cnt <= '0;
        S_WAIT_DONE: begin
          cnt <= cnt + CNT_W'(1);
          if (i_fib_done) begin
            o_result_amt_bcd1 <= amt1;
            o_result_amt_bcd0 <= amt0;
            {o_result_bcd3, o_result_bcd2, o_result_bcd1, o_result_bcd0}
              <= {i_fib_bcd3, i_fib_bcd2, i_fib_bcd1, i_fib_bcd0};
            o_result_ovf <= i_fib_overflow;
          end else if (timeout) begin
            o_err <= 1'b1;
          end
        end
        S_REPORT: if (o_result_ovf && !o_first_ovf_valid) begin
          o_first_ovf_valid <= 1'b1;
          o_first_ovf_bcd1  <= o_result_amt_bcd1;
          o_first_ovf_bcd0  <= o_result_amt_bcd0;
        end
        S_NEXT: {amt1, amt0} <= {amt1_inc, amt0_inc};
        default: ;
      endcase
    end
  end

  assign o_fib_start    = (state == S_START);
  assign o_fib_amt_bcd1 = amt1;
  assign o_fib_amt_bcd0 = amt0;
  assign o_busy         = (state != S_IDLE);
  assign o_result_valid = (state == S_REPORT);
  assign o_sweep_done   = (state == S_FINISH);

endmodule

// File: tb/tb_fibgen_sweep_ctrl.sv
// Directed bench: two controllers (default and short-timeout/no-stop) share a behavioural fibgen.
module tb_fibgen_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       sel = 1'b0;
  logic       kill_done = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] lo1 = '0, lo0 = '0, hi1 = '0, hi0 = '0;
  logic       go [2];

  logic       fib_start [2];
  logic [3:0] fib_a1 [2], fib_a0 [2];
  logic       busy [2], rvalid [2], rovf [2], fov [2], sdone [2], err [2];
  logic [3:0] ramt1 [2], ramt0 [2], rd3 [2], rd2 [2], rd1 [2], rd0 [2], fo1 [2], fo0 [2];
  logic       fdone [2];

  logic        m_ready, m_done_raw, m_busy, m_ovf;
  logic [15:0] m_res;
  int          m_cnt, m_n;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign fdone[g] = m_done_raw && (int'(sel) == g) && !kill_done;
    fibgen_sweep_ctrl #(
      .TIMEOUT_CYCLES (g == 0 ? 1024 : 16),
      .STOP_ON_OVF    (g == 0 ? 1 : 0)
    ) dut (
      .i_clk (clk), .i_rst_n (rst_n), .i_sweep_start (go[g]), .i_stop (stop),
      .i_lo_bcd1 (lo1), .i_lo_bcd0 (lo0), .i_hi_bcd1 (hi1), .i_hi_bcd0 (hi0),
      .o_fib_start (fib_start[g]), .o_fib_amt_bcd1 (fib_a1[g]), .o_fib_amt_bcd0 (fib_a0[g]),
      .i_fib_ready (m_ready), .i_fib_done (fdone[g]), .i_fib_overflow (m_ovf),
      .i_fib_bcd3 (m_res[15:12]), .i_fib_bcd2 (m_res[11:8]),
      .i_fib_bcd1 (m_res[7:4]), .i_fib_bcd0 (m_res[3:0]),
      .o_busy (busy[g]), .o_result_valid (rvalid[g]),
      .o_result_amt_bcd1 (ramt1[g]), .o_result_amt_bcd0 (ramt0[g]),
      .o_result_bcd3 (rd3[g]), .o_result_bcd2 (rd2[g]),
      .o_result_bcd1 (rd1[g]), .o_result_bcd0 (rd0[g]),
      .o_result_ovf (rovf[g]), .o_first_ovf_valid (fov[g]),
      .o_first_ovf_bcd1 (fo1[g]), .o_first_ovf_bcd0 (fo0[g]),
      .o_sweep_done (sdone[g]), .o_err (err[g])
    );
  end

  function automatic int fib(input int n);
    int a = 0, b = 1, t;
    for (int i = 0; i < n; i++) begin
      t = a + b; a = b; b = t;
    end
    return a;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Behavioural fibgen: fixed 5-cycle latency, overflow above 9999.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_ready <= 1'b1; m_done_raw <= 1'b0;
      m_cnt <= 0; m_n <= 0; m_ovf <= 1'b0; m_res <= '0;
    end else begin
      m_done_raw <= 1'b0;
      if (!m_busy) begin
        if (fib_start[sel]) begin
          m_busy <= 1'b1; m_ready <= 1'b0; m_cnt <= 5;
          m_n <= int'(fib_a1[sel]) * 10 + int'(fib_a0[sel]);
        end
      end else if (m_cnt == 1) begin
        m_busy <= 1'b0; m_ready <= 1'b1; m_done_raw <= 1'b1;
        m_ovf <= (fib(m_n) > 9999);
        m_res <= to_bcd(fib(m_n) % 10000);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Monitor of the selected controller; entry = {amt[24:17], digits[16:1], ovf[0]}.
  logic [24:0] res_q [$];
  int          n_starts = 0, n_done = 0, t_fs = 0, t_done = 0;
  logic        err_done = 1'b0;
  logic [8:0]  fo_done = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fib_start[sel]) begin n_starts++; t_fs = cyc; end
      if (rvalid[sel])
        res_q.push_back({ramt1[sel], ramt0[sel], rd3[sel], rd2[sel], rd1[sel], rd0[sel], rovf[sel]});
      if (sdone[sel]) begin
        n_done++; t_done = cyc; err_done = err[sel]; fo_done = {fov[sel], fo1[sel], fo0[sel]};
      end
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int base_r, base_s, base_d, t_go;

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic run_sweep(input logic s, input logic [7:0] lo, input logic [7:0] hi);
    sel = s; {lo1, lo0} = lo; {hi1, hi0} = hi;
    base_r = res_q.size(); base_s = n_starts; base_d = n_done;
    tick(); t_go = cyc; go[s] = 1'b1;
    tick(); go[s] = 1'b0;
    for (int i = 0; i < 3000 && n_done == base_d; i++) tick();
    repeat (3) tick();
    check("sweep_done_count", 64'(n_done - base_d), 64'd1);
  endtask

  task automatic chk_res(input string tag, input int idx, input logic [7:0] amt,
                         input logic [15:0] val, input logic ovf);
    logic [24:0] e;
    e = (base_r + idx < res_q.size()) ? res_q[base_r + idx] : '1;
    check({tag, "_amt"}, 64'(e[24:17]), 64'(amt));
    check({tag, "_val"}, 64'(e[16:1]), 64'(val));
    check({tag, "_ovf"}, 64'(e[0]), 64'(ovf));
  endtask

  logic [15:0] exp1 [6];
  logic [7:0]  e_amt;
  logic [46:0] outs_a;
  assign outs_a = {fib_start[0], fib_a1[0], fib_a0[0], busy[0], rvalid[0], ramt1[0], ramt0[0],
                   rd3[0], rd2[0], rd1[0], rd0[0], rovf[0], fov[0], fo1[0], fo0[0], sdone[0], err[0]};

  initial begin
    go[0] = 1'b0; go[1] = 1'b0;
    exp1 = '{16'h0000, 16'h0001, 16'h0001, 16'h0002, 16'h0003, 16'h0005};
    #3;
    check("reset_outputs", 64'(outs_a), 64'd0);
    tick(); rst_n = 1'b1;
    repeat (2) tick();

    // 1: 00..05
    run_sweep(1'b0, 8'h00, 8'h05);
    check("t1_results", 64'(res_q.size() - base_r), 64'd6);
    for (int i = 0; i < 6; i++) begin
      e_amt = 8'(i);
      chk_res("t1", i, e_amt, exp1[i], 1'b0);
    end
    check("t1_err", 64'(err_done), 64'd0);
    check("t1_first_ovf", 64'(fo_done), 64'd0);

    // 2: 18..25 stops at first overflow (21)
    run_sweep(1'b0, 8'h18, 8'h25);
    check("t2_results", 64'(res_q.size() - base_r), 64'd4);
    chk_res("t2_18", 0, 8'h18, 16'h2584, 1'b0);
    chk_res("t2_19", 1, 8'h19, 16'h4181, 1'b0);
    chk_res("t2_20", 2, 8'h20, 16'h6765, 1'b0);
    check("t2_ovf_amt", 64'(res_q[base_r + 3][24:17]), 64'h21);
    check("t2_ovf_flag", 64'(res_q[base_r + 3][0]), 64'd1);
    check("t2_first_ovf", 64'(fo_done), 64'h121);

    // 4: bad configs
    run_sweep(1'b0, 8'h07, 8'h03);
    check("t4_err", 64'(err_done), 64'd1);
    check("t4_starts", 64'(n_starts - base_s), 64'd0);
    check("t4_latency", 64'(t_done - t_go), 64'd2);
    check("t4_first_ovf_cleared", 64'(fo_done), 64'd0);
    run_sweep(1'b0, 8'h0A, 8'h20);
    check("t4b_err", 64'(err_done), 64'd1);
    check("t4b_starts", 64'(n_starts - base_s), 64'd0);
    check("t4b_latency", 64'(t_done - t_go), 64'd2);

    // 5: 00..99, stop during amt 10, extra start at amt 05 ignored
    sel = 1'b0; {lo1, lo0} = 8'h00; {hi1, hi0} = 8'h99;
    base_r = res_q.size(); base_s = n_starts; base_d = n_done;
    tick(); go[0] = 1'b1;
    for (int i = 0; i < 2000 && n_done == base_d; i++) begin
      tick();
      go[0] = 1'b0;
      if (fib_start[0] && {fib_a1[0], fib_a0[0]} == 8'h05) go[0] = 1'b1;
      if (fib_start[0] && {fib_a1[0], fib_a0[0]} == 8'h10) stop = 1'b1;
    end
    go[0] = 1'b0;
    repeat (3) tick();
    stop = 1'b0;
    check("t5_done_count", 64'(n_done - base_d), 64'd1);
    check("t5_results", 64'(res_q.size() - base_r), 64'd11);
    check("t5_starts", 64'(n_starts - base_s), 64'd11);
    chk_res("t5_first", 0, 8'h00, 16'h0000, 1'b0);
    chk_res("t5_last", 10, 8'h10, 16'h0055, 1'b0);
    check("t5_err", 64'(err_done), 64'd0);

    // 6a: async reset mid-sweep
    sel = 1'b0; {lo1, lo0} = 8'h00; {hi1, hi0} = 8'h05;
    base_s = n_starts;
    tick(); go[0] = 1'b1;
    tick(); go[0] = 1'b0;
    for (int i = 0; i < 100 && n_starts == base_s; i++) tick();
    tick();
    check("t6_busy_before_reset", 64'(busy[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("t6_async_reset_outputs", 64'(outs_a), 64'd0);
    tick(); rst_n = 1'b1;
    repeat (2) tick();

    // 3: second controller, no stop on overflow
    run_sweep(1'b1, 8'h18, 8'h25);
    check("t3_results", 64'(res_q.size() - base_r), 64'd8);
    chk_res("t3_19", 1, 8'h19, 16'h4181, 1'b0);
    chk_res("t3_20", 2, 8'h20, 16'h6765, 1'b0);
    check("t3_last_amt", 64'(res_q[base_r + 7][24:17]), 64'h25);
    check("t3_last_ovf", 64'(res_q[base_r + 7][0]), 64'd1);
    check("t3_first_ovf", 64'(fo_done), 64'h121);
    check("t3_err", 64'(err_done), 64'd0);

    // 6b: fibgen done suppressed -> timeout after 16 WAIT_DONE cycles
    kill_done = 1'b1;
    run_sweep(1'b1, 8'h00, 8'h00);
    kill_done = 1'b0;
    check("t6_timeout_err", 64'(err_done), 64'd1);
    check("t6_timeout_cycles", 64'(t_done - t_fs), 64'd17);
    check("t6_timeout_results", 64'(res_q.size() - base_r), 64'd0);
    check("t6_timeout_starts", 64'(n_starts - base_s), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
